// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction memory writer.
// Packs a valid/ready byte stream little-endian into 32-bit words and writes
// them at word-aligned addresses from 0 upward, holding the core in reset
// until the whole image is written.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (running sum of written words).
module imem_loader #(
    parameter int unsigned HEIGHT = 256
) (
    input  logic        i_Clk,
    input  logic        i_Rst_n,
    input  logic        i_Start,
    input  logic [31:0] i_Length,
    input  logic [7:0]  i_Byte,
    input  logic        i_Byte_Valid,
    output logic        o_Byte_Ready,
    output logic        o_Wr_En,
    output logic [31:0] o_Wr_Addr,
    output logic [31:0] o_Wr_Data,
    output logic        o_Busy,
    output logic        o_Done,
    output logic        o_Core_Rst_n,
    output logic [31:0] o_Checksum
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [31:0] HEIGHT_W = 32'(HEIGHT);

    logic [1:0]  state;
    logic [31:0] byte_cnt;
    logic [31:0] eff_len;
    logic [31:0] wr_addr;
    logic [31:0] word_buf;
    logic [1:0]  lane;

    logic [31:0] start_len;
    logic        start_ok;
    logic        last_byte;

    // Clamped length, start qualification and word-complete detection
    always_comb begin
        start_len = (i_Length > HEIGHT_W) ? HEIGHT_W : i_Length;
        start_ok  = i_Start && ((state == ST_IDLE) || (state == ST_DONE));
        last_byte = (lane == 2'd3) || ((byte_cnt + 32'd1) == eff_len);
    end

    // Main load sequencer: byte packing, word write pacing and address stepping
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            state    <= ST_IDLE;
            byte_cnt <= '0;
            eff_len  <= '0;
            wr_addr  <= '0;
            word_buf <= '0;
            lane     <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_ok) begin
                        byte_cnt <= '0;
                        eff_len  <= start_len;
                        wr_addr  <= '0;
                        word_buf <= '0;
                        lane     <= '0;
                        state    <= (start_len == '0) ? ST_DONE : ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // Ready is unconditionally high in LOAD, so valid alone accepts
                    if (i_Byte_Valid) begin
                        word_buf[{lane, 3'b000} +: 8] <= i_Byte;
                        lane     <= lane + 2'd1;
                        byte_cnt <= byte_cnt + 32'd1;
                        if (last_byte) begin
                            state <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    wr_addr  <= wr_addr + 32'd4;
                    word_buf <= '0;
                    lane     <= '0;
                    state    <= (byte_cnt == eff_len) ? ST_DONE : ST_LOAD;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] checksum;

    // Running sum of every written word, restarted by reset or an accepted start
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            checksum <= '0;
        end else if (start_ok) begin
            checksum <= '0;
        end else if (state == ST_WRITE) begin
            checksum <= checksum + word_buf;
        end
    end

    assign o_Checksum = checksum;
`else
    assign o_Checksum = '0;
`endif

    // Outputs decoded from state and registers only
    always_comb begin
        o_Byte_Ready = (state == ST_LOAD);
        o_Wr_En      = (state == ST_WRITE);
        o_Wr_Addr    = wr_addr;
        o_Wr_Data    = word_buf;
        o_Busy       = (state == ST_LOAD) || (state == ST_WRITE);
        o_Done       = (state == ST_DONE);
        o_Core_Rst_n = (state == ST_DONE);
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed + randomized bench for imem_loader.
// Writes are captured into a byte-array instruction memory; expectations come
// from packing the stimulus image directly.
module tb_imem_loader;

    localparam int HEIGHT = 256;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] length;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        core_rst_n;
    logic [31:0] checksum;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    imem_loader #(.HEIGHT(HEIGHT)) dut (
        .i_Clk        (clk),
        .i_Rst_n      (rst_n),
        .i_Start      (start),
        .i_Length     (length),
        .i_Byte       (byte_in),
        .i_Byte_Valid (byte_valid),
        .o_Byte_Ready (byte_ready),
        .o_Wr_En      (wr_en),
        .o_Wr_Addr    (wr_addr),
        .o_Wr_Data    (wr_data),
        .o_Busy       (busy),
        .o_Done       (done),
        .o_Core_Rst_n (core_rst_n),
        .o_Checksum   (checksum)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Captured write log and the instruction memory image it builds
    logic [31:0] wq_addr[$];
    logic [31:0] wq_data[$];
    int          wq_cyc[$];
    int          done_rise = -1;
    logic        done_prev = 1'b0;
    logic [7:0]  mem [0:HEIGHT-1];
    logic [7:0]  img [0:511];

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wq_addr.push_back(wr_addr);
            wq_data.push_back(wr_data);
            wq_cyc.push_back(cyc);
            for (int b = 0; b < 4; b++) begin
                if (int'(wr_addr) + b < HEIGHT)
                    mem[int'(wr_addr) + b] = wr_data[8*b +: 8];
            end
        end
        if (done === 1'b1 && done_prev !== 1'b1) done_rise = cyc;
        done_prev = done;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic [31:0] len);
        @(negedge clk);
        start  = 1'b1;
        length = len;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Offer img[0..n-1]; a byte counts as taken when valid and ready coincide
    task automatic send(input int n, input int gap_pct, input string tag);
        int idx   = 0;
        int guard = 0;
        logic v;
        while (idx < n && guard < 5000) begin
            v          = (int'($urandom_range(99)) >= gap_pct);
            byte_in    = img[idx];
            byte_valid = v;
            if (v && byte_ready === 1'b1) idx++;
            @(negedge clk);
            guard++;
        end
        byte_valid = 1'b0;
        chk({tag, "_stream_count"}, 64'(idx), 64'(n));
    endtask

    task automatic wait_done(input int budget, input string tag);
        int k = 0;
        while (done !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        #2;
        chk({tag, "_done"}, 64'(done), 64'(1));
    endtask

    // Expected writes: ceil(eff/4) words, packed LE, zero past the image end
    task automatic check_load(input int len, input int base, input string tag);
        int eff = (len > HEIGHT) ? HEIGHT : len;
        int nw  = (eff + 3) / 4;
        int got = wq_addr.size() - base;
        logic [31:0] w;
        logic [31:0] sum = '0;
        chk({tag, "_nwrites"}, 64'(got), 64'(nw));
        for (int k = 0; k < nw && k < got; k++) begin
            w = '0;
            for (int b = 0; b < 4; b++) begin
                if (4*k + b < eff) w = w | (32'(img[4*k + b]) << (8*b));
            end
            sum = sum + w;
            chk($sformatf("%s_addr%0d", tag, k), 64'(wq_addr[base + k]), 64'(4*k));
            chk($sformatf("%s_data%0d", tag, k), 64'(wq_data[base + k]), 64'(w));
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk({tag, "_checksum"}, 64'(checksum), 64'(sum));
`else
        chk({tag, "_checksum"}, 64'(checksum), 64'(0));
`endif
    endtask

    initial begin
        int base;
        int rdy_cnt;
        logic [31:0] w;

        rst_n      = 1'b0;
        start      = 1'b0;
        length     = '0;
        byte_in    = '0;
        byte_valid = 1'b0;
        repeat (3) @(negedge clk);

        chk("reset_flags", 64'({byte_ready, wr_en, busy, done, core_rst_n}), 64'(0));
        chk("reset_addr", 64'(wr_addr), 64'(0));
        chk("reset_data", 64'(wr_data), 64'(0));
        chk("reset_cksum", 64'(checksum), 64'(0));
        rst_n = 1'b1;

        // Zero length: DONE one cycle after start, no writes
        base = wq_addr.size();
        pulse_start(32'd0);
        chk("zero_done", 64'({done, core_rst_n, busy}), 64'(3'b110));
        repeat (3) @(negedge clk);
        chk("zero_nwrites", 64'(wq_addr.size() - base), 64'(0));

        // Full words back-to-back, restarted from DONE
        for (int i = 0; i < 8; i++) img[i] = 8'(i);
        base = wq_addr.size();
        pulse_start(32'd8);
        chk("full_restart", 64'({core_rst_n, busy, done}), 64'(3'b010));
        send(8, 0, "full");
        wait_done(50, "full");
        check_load(8, base, "full");
        if (wq_cyc.size() >= base + 2) begin
            chk("full_word_spacing", 64'(wq_cyc[base+1] - wq_cyc[base]), 64'(5));
            chk("full_done_lat", 64'(done_rise - wq_cyc[base+1]), 64'(1));
        end
        chk("full_core_rst", 64'(core_rst_n), 64'(1));

        // Partial final word
        for (int i = 0; i < 6; i++) img[i] = 8'(8'h11 + i);
        base = wq_addr.size();
        pulse_start(32'd6);
        send(6, 0, "partial");
        wait_done(50, "partial");
        check_load(6, base, "partial");

        // Valid held high through WRITE: byte 0xAA lands in lane 0 of word 1
        img[0] = 8'h01; img[1] = 8'h02; img[2] = 8'h03; img[3] = 8'h04;
        img[4] = 8'hAA; img[5] = 8'hBB; img[6] = 8'hCC; img[7] = 8'hDD;
        base = wq_addr.size();
        pulse_start(32'd8);
        send(8, 0, "bp");
        wait_done(50, "bp");
        check_load(8, base, "bp");

        // Random gaps in the stream
        for (int i = 0; i < 23; i++) img[i] = 8'($urandom);
        base = wq_addr.size();
        pulse_start(32'd23);
        send(23, 40, "gaps");
        wait_done(50, "gaps");
        check_load(23, base, "gaps");

        // Length clamp: 300 requested, only HEIGHT bytes accepted
        for (int i = 0; i < 300; i++) img[i] = 8'($urandom);
        base = wq_addr.size();
        pulse_start(32'd300);
        send(HEIGHT, 0, "clamp");
        rdy_cnt    = 0;
        byte_valid = 1'b1;
        byte_in    = img[HEIGHT];
        for (int i = 0; i < 12; i++) begin
            if (byte_ready === 1'b1) rdy_cnt++;
            @(negedge clk);
        end
        byte_valid = 1'b0;
        chk("clamp_extra_ready", 64'(rdy_cnt), 64'(0));
        wait_done(50, "clamp");
        check_load(300, base, "clamp");
        if (wq_addr.size() > base) chk("clamp_last_addr", 64'(wq_addr[wq_addr.size()-1]), 64'(252));

        // Reset after 3 accepted bytes, then a clean 4-byte load
        img[0] = 8'h5A; img[1] = 8'h6B; img[2] = 8'h7C;
        base = wq_addr.size();
        pulse_start(32'd16);
        send(3, 0, "abort");
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_flags", 64'({byte_ready, wr_en, busy, done, core_rst_n}), 64'(0));
        chk("abort_addr", 64'(wr_addr), 64'(0));
        chk("abort_data", 64'(wr_data), 64'(0));
        chk("abort_cksum", 64'(checksum), 64'(0));
        chk("abort_nwrites", 64'(wq_addr.size() - base), 64'(0));
        rst_n = 1'b1;
        img[0] = 8'hA1; img[1] = 8'hA2; img[2] = 8'hA3; img[3] = 8'hA4;
        base = wq_addr.size();
        pulse_start(32'd4);
        send(4, 0, "after_abort");
        wait_done(50, "after_abort");
        check_load(4, base, "after_abort");

        // Full random image, then read back every word from the memory model
        for (int i = 0; i < HEIGHT; i++) img[i] = 8'($urandom);
        base = wq_addr.size();
        pulse_start(32'(HEIGHT));
        send(HEIGHT, 20, "image");
        wait_done(50, "image");
        check_load(HEIGHT, base, "image");
        for (int a = 0; a < HEIGHT; a += 4) begin
            w = {mem[a+3], mem[a+2], mem[a+1], mem[a]};
            chk($sformatf("readback_%0d", a), 64'(w),
                64'({img[a+3], img[a+2], img[a+1], img[a]}));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the instruction memory. Accepts a byte stream over a valid/ready handshake, packs bytes little-endian into 32-bit words (byte at address a+0 is bits 7:0, a+3 is bits 31:24), and issues word writes at word-aligned byte addresses from 0 upward. It holds the core in reset until the load completes. After the load, the instruction memory's combinational word read at any address returns exactly the loaded bytes.

## Interface
- HEIGHT, 256, instruction memory size in bytes; multiple of 4.
- i_Clk  in  1  clock; all state updates on rising edge.
- i_Rst_n  in  1  synchronous active-low reset.
- i_Start  in  1  single-cycle pulse; begins a load; honoured only in IDLE or DONE.
- i_Length  in  32  byte count of the image, sampled on the i_Start cycle.
- i_Byte  in  8  stream data.
- i_Byte_Valid  in  1  stream data valid.
- o_Byte_Ready  out  1  loader can accept a byte this cycle.
- o_Wr_En  out  1  one-cycle word write strobe to instruction memory.
- o_Wr_Addr  out  32  byte address of the write; always a multiple of 4.
- o_Wr_Data  out  32  packed little-endian word.
- o_Busy  out  1  high in LOAD and WRITE.
- o_Done  out  1  high in DONE.
- o_Core_Rst_n  out  1  low holds the core in reset; high only in DONE.
- o_Checksum  out  32  sum of all written words; see Configuration.

## Operation
- States: IDLE, LOAD, WRITE, DONE.
- Registers: byte counter, lane index 0–3, word buffer, write address, effective length.
- IDLE → LOAD on i_Start.
  - Effective length is min(i_Length, HEIGHT).
  - If the effective length is 0, go IDLE → DONE instead, with no writes.
- LOAD:
  - o_Byte_Ready = 1.
  - A byte is accepted when i_Byte_Valid & o_Byte_Ready.
  - The accepted byte goes into buffer lane `lane`, bits [8*lane+7 : 8*lane].
  - Then lane and the byte counter increment.
- LOAD → WRITE when the accepted byte fills lane 3 or is the last byte of the effective length.
  - Unfilled lanes of a partial final word are written as 0x00.
- WRITE:
  - o_Wr_En = 1; o_Wr_Data = buffer; o_Wr_Addr = current address; o_Byte_Ready = 0.
  - Then the address increments by 4, the buffer clears to 0, and lane resets to 0.
  - Next state is DONE if the byte counter equals the effective length, otherwise LOAD.
- DONE:
  - o_Done = 1 and o_Core_Rst_n = 1; o_Byte_Ready = 0.
  - Incoming bytes are ignored.
  - i_Start goes back to LOAD: address, counter, lane, buffer and checksum all restart from 0, and o_Core_Rst_n drops in that same next cycle.
- i_Start is ignored in LOAD and WRITE.
- Bytes beyond the effective length are never accepted.
- Reset mid-load aborts immediately. The next load starts from address 0.
- Reset values: state IDLE, o_Byte_Ready 0, o_Wr_En 0, o_Wr_Addr 0, o_Wr_Data 0, o_Busy 0, o_Done 0, o_Core_Rst_n 0, o_Checksum 0.

## Timing
- All outputs are registered or decoded from the state; there is no combinational path from inputs to outputs.
- The byte that completes a word is accepted in cycle n; o_Wr_En is high in cycle n+1.
- The first byte of the next word can be accepted in cycle n+2.
- Peak throughput is 4 bytes per 5 cycles.
- o_Done and o_Core_Rst_n rise in the cycle after the final WRITE cycle.
- A zero-length load reaches DONE one cycle after i_Start.
- A stalled stream (i_Byte_Valid low) simply holds LOAD with no timeout.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - o_Checksum accumulates o_Wr_Data in each WRITE cycle, mod 2^32.
  - The update is visible the cycle after the write.
  - It is cleared on reset and on each accepted i_Start.
- IMEM_LOADER_CHECKSUM_EN undefined:
  - No accumulator is built; o_Checksum is constant 0.

## Test plan
- Full words: HEIGHT 256, length 8, bytes 00..07 sent back-to-back → writes 0x03020100 @0 and 0x07060504 @4; o_Done and o_Core_Rst_n high one cycle after the second write; checksum 0x0A080604 (macro on).
- Partial word: length 6, bytes 11..16 → writes 0x14131211 @0 and 0x00001615 @4; exactly 2 o_Wr_En pulses.
- Zero length and clamp:
  - Length 0 → DONE one cycle after i_Start, no o_Wr_En.
  - Length 300 → exactly 64 writes, last at address 252; bytes after the 256th see o_Byte_Ready 0.
- Backpressure/gaps: i_Byte_Valid held high across a WRITE cycle with byte 0xAA → 0xAA is not lost; it lands in lane 0 of the next word. Random valid gaps give identical write data.
- Reset mid-load: reset after 3 bytes accepted → all outputs at reset values next cycle. A new load of 4 bytes then writes to address 0 with no stale lanes.
- Readback: load a 256-byte random image, then read the instruction memory at addresses 0, 4, … 252 → each word equals {b[a+3], b[a+2], b[a+1], b[a]}.
